// File: rtl/load_store_unit_if.sv
// Bus bundle between a CPU-side requester, the load/store unit and data memory.
// The unit uses the slave modport; the requester/memory side (e.g. a testbench) uses master.
interface load_store_unit_if;
    logic        start;
    logic        mem_write_enable;
    logic [1:0]  bit_half_word_select;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;

    modport slave (
        input  start, mem_write_enable, bit_half_word_select, is_unsigned, addr, wdata,
               dmem_ready, dmem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, busy, done, fault, rdata
    );

    modport master (
        output start, mem_write_enable, bit_half_word_select, is_unsigned, addr, wdata,
               dmem_ready, dmem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, busy, done, fault, rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit with alignment checking and lane steering.
// Define LSU_TIMEOUT_EN to bound the data-memory wait to TIMEOUT_CYCLES REQ cycles.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic        we_reg, us_reg, fault_reg;
    logic [1:0]  sel_reg;
    logic [31:0] addr_reg, wdata_reg, rdata_reg;
    logic [3:0]  be_reg;

    logic        start_ok;
    logic [3:0]  start_be;
    logic [31:0] start_wdata;
    logic [31:0] lane_word;
    logic [31:0] load_value;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_must_be_positive
        logic bad_parameter;
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             wait_expired;
    assign wait_expired = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Decode of the op presented with start; captured only when the op is accepted.
    always_comb begin
        start_ok    = 1'b0;
        start_be    = 4'b0000;
        start_wdata = 32'd0;
        case (bus.bit_half_word_select)
            2'b00: begin
                start_ok    = 1'b1;
                start_be    = 4'b0001 << bus.addr[1:0];
                start_wdata = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                start_ok    = ~bus.addr[0];
                start_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
                start_wdata = {2{bus.wdata[15:0]}};
            end
            2'b10: begin
                start_ok    = (bus.addr[1:0] == 2'b00);
                start_be    = 4'b1111;
                start_wdata = bus.wdata;
            end
            default: begin
                start_ok    = 1'b0;
                start_be    = 4'b0000;
                start_wdata = 32'd0;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend by size.
    assign lane_word = bus.dmem_rdata >> {addr_reg[1:0], 3'b000};

    always_comb begin
        load_value = lane_word;
        case (sel_reg)
            2'b00:   load_value = {{24{~us_reg & lane_word[7]}}, lane_word[7:0]};
            2'b01:   load_value = {{16{~us_reg & lane_word[15]}}, lane_word[15:0]};
            default: load_value = lane_word;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (bus.start) state_next = start_ok ? ST_REQ : ST_RESP;
            ST_REQ: begin
                if (bus.dmem_ready) state_next = ST_RESP;
`ifdef LSU_TIMEOUT_EN
                else if (wait_expired) state_next = ST_RESP;
`endif
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            we_reg    <= 1'b0;
            us_reg    <= 1'b0;
            fault_reg <= 1'b0;
            sel_reg   <= 2'b00;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
            be_reg    <= 4'b0000;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        we_reg    <= bus.mem_write_enable;
                        us_reg    <= bus.is_unsigned;
                        sel_reg   <= bus.bit_half_word_select;
                        addr_reg  <= bus.addr;
                        wdata_reg <= start_wdata;
                        be_reg    <= start_be;
                        fault_reg <= ~start_ok;
`ifdef LSU_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (bus.dmem_ready) begin
                        if (!we_reg) rdata_reg <= load_value;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_expired) fault_reg <= 1'b1;
                    else wait_cnt_reg <= wait_cnt_reg + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from reset-cleared state so reset takes effect without a clock.
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.done       = (state_reg == ST_RESP);
    assign bus.fault      = fault_reg;
    assign bus.rdata      = rdata_reg;
    assign bus.dmem_req   = (state_reg == ST_REQ);
    assign bus.dmem_we    = bus.dmem_req & we_reg;
    assign bus.dmem_addr  = {addr_reg[31:2], 2'b00};
    assign bus.dmem_wdata = wdata_reg;
    // Byte enables qualify write lanes only; reads always return the full word.
    assign bus.dmem_be    = (bus.dmem_req & we_reg) ? be_reg : 4'b0000;
endmodule
